// File: rtl/ps2_scancode_rx_if.sv
// Decoded PS/2 key event bundle.
// Master drives the event, slave is the keypad-emulation consumer.
interface ps2_scancode_rx_if;
    logic [7:0] key_code_o;
    logic       key_extended_o;
    logic       key_pressed_o;
    logic       key_strobe_o;
    logic       frame_err_o;

    modport master (
        output key_code_o,
        output key_extended_o,
        output key_pressed_o,
        output key_strobe_o,
        output frame_err_o
    );

    modport slave (
        input key_code_o,
        input key_extended_o,
        input key_pressed_o,
        input key_strobe_o,
        input frame_err_o
    );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver folding E0/F0/E1 prefixes into key events.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_scancode_rx #(
    parameter int CLK_KHZ    = 21477,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          ps2_clk_i,
    input  logic          ps2_dat_i,
    ps2_scancode_rx_if.master key
);

    localparam int TO_CYC = CLK_KHZ * TIMEOUT_US / 1000;
    localparam int TOW    = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {
        IDLE, DATA, PARITY, STOP
    } state_t;

    logic [1:0]     clk_sync;
    logic [1:0]     dat_sync;
    logic           filt;
    logic [7:0]     flt_cnt;
    logic           bit_ev;
    logic           dat_s;

    state_t         state;
    logic [2:0]     bit_cnt;
    logic [7:0]     sh;
    logic [TOW-1:0] to_cnt;
    logic           timeout;
    logic           par_ok;
    logic           ext_flag;
    logic           rel_flag;
    logic [2:0]     skip_cnt;

    logic [7:0]     code_q;
    logic           ext_q;
    logic           prs_q;
    logic           stb_q;
    logic           err_q;

    assign dat_s  = dat_sync[1];
    // Flip cycle of a high-to-low filtered clock transition.
    assign bit_ev = filt && !clk_sync[1]
                 && (flt_cnt == 8'(FILTER_LEN - 1));

    assign timeout = (state != IDLE) && !bit_ev
                  && (to_cnt == '0);

`ifdef PS2_PARITY_CHECK_EN
    logic par;
    assign par_ok = ^{sh, par};
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            flt_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
            if (clk_sync[1] == filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == 8'(FILTER_LEN - 1)) begin
                filt    <= clk_sync[1];
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sh       <= '0;
            to_cnt   <= '0;
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
            skip_cnt <= '0;
            code_q   <= '0;
            ext_q    <= 1'b0;
            prs_q    <= 1'b0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par      <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
            if (bit_ev)
                to_cnt <= TOW'(TO_CYC);
            else if (state != IDLE && to_cnt != '0)
                to_cnt <= to_cnt - 1'b1;

            if (timeout) begin
                state    <= IDLE;
                err_q    <= 1'b1;
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
                skip_cnt <= '0;
            end else if (bit_ev) begin
                unique case (state)
                    IDLE: begin
                        if (!dat_s) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            err_q    <= 1'b1;
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                            skip_cnt <= '0;
                        end
                    end
                    DATA: begin
                        sh      <= {dat_s, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par   <= dat_s;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (dat_s && par_ok) begin
                            if (skip_cnt != '0) begin
                                skip_cnt <= skip_cnt - 3'd1;
                            end else begin
                                unique case (sh)
                                    8'hE1: skip_cnt <= 3'd7;
                                    8'hE0: ext_flag <= 1'b1;
                                    8'hF0: rel_flag <= 1'b1;
                                    default: begin
                                        code_q   <= sh;
                                        ext_q    <= ext_flag;
                                        prs_q    <= ~rel_flag;
                                        stb_q    <= ~stb_q;
                                        ext_flag <= 1'b0;
                                        rel_flag <= 1'b0;
                                    end
                                endcase
                            end
                        end else begin
                            err_q    <= 1'b1;
                            ext_flag <= 1'b0;
                            rel_flag <= 1'b0;
                            skip_cnt <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign key.key_code_o     = code_q;
    assign key.key_extended_o = ext_q;
    assign key.key_pressed_o  = prs_q;
    assign key.key_strobe_o   = stb_q;
    assign key.frame_err_o    = err_q;

endmodule
